uart_fpga: RTL and testbench

Bit-serial UART transceiver modelling the FPGA side of the LArPix control and readout link. The TX path serialises WIDTH-bit command words onto the chip's serial input (posi). The RX path deserialises WIDTH-bit packets from the chip's serial output (piso) into a one-word holding register with an empty flag and a parity check. It sits between the master-control logic and the chip pins; both directions run one bit per clk cycle.

---
 rtl/uart_fpga_pkg.sv | 23 ++
 rtl/uart_fpga_rx.sv | 100 ++++++++++
 rtl/uart_fpga.sv | 88 ++++++++
 tb/tb_uart_fpga.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fpga_pkg.sv
// Shared types and constants for the uart_fpga transceiver.
package uart_fpga_pkg;

    localparam int DEFAULT_WIDTH = 64;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_fpga_rx.sv
// Receive path: start-bit detect, LSB-first deserialiser, one-word holding register.
// Parity reporting is built only when UART_PARITY_CHECK_EN is defined.
module uart_fpga_rx
    import uart_fpga_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_in,
    input  logic             uld_rx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_empty,
    output logic             parity_error
);

    localparam int CW = $clog2(WIDTH + 1);

    rx_state_t        state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] rx_data_reg;
    logic             rx_empty_reg;
    logic             frame_done;

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        frame_done = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (rx_in == START_BIT) begin
                    state_next = RX_DATA;
                    cnt_next   = '0;
                end
            end
            RX_DATA: begin
                shift_next = {rx_in, shift_reg[WIDTH-1:1]};
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1))
                    state_next = RX_STOP;
            end
            RX_STOP: begin
                if (rx_in == STOP_BIT) begin
                    frame_done = 1'b1;
                    state_next = RX_IDLE;
                end else begin
                    state_next = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_in == STOP_BIT)
                    state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // A completing frame takes priority over a same-cycle unload strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RX_IDLE;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            rx_data_reg  <= '0;
            rx_empty_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            if (frame_done) begin
                rx_data_reg  <= shift_reg;
                rx_empty_reg <= 1'b0;
            end else if (uld_rx_data) begin
                rx_empty_reg <= 1'b1;
            end
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_empty = rx_empty_reg;

`ifdef UART_PARITY_CHECK_EN
    logic parity_error_reg;

    // Packets carry odd parity, so an even bit count flags an error.
    always_ff @(posedge clk) begin
        if (reset)
            parity_error_reg <= 1'b0;
        else if (frame_done)
            parity_error_reg <= ~^shift_reg;
    end

    assign parity_error = parity_error_reg;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: rtl/uart_fpga.sv
// FPGA-side LArPix UART: inline TX serialiser plus the uart_fpga_rx receiver.
// Optional parity reporting is enabled with UART_PARITY_CHECK_EN.
module uart_fpga
    import uart_fpga_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             ld_tx_data,
    input  logic             tx_enable,
    output logic             tx_out,
    output logic             tx_busy,
    input  logic             rx_in,
    input  logic             uld_rx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_empty,
    output logic             parity_error
);

    localparam int CW = $clog2(WIDTH + 1);

    tx_state_t        tx_state_reg, tx_state_next;
    logic [WIDTH-1:0] tx_shift_reg, tx_shift_next;
    logic [CW-1:0]    tx_cnt_reg, tx_cnt_next;

    // Line level and busy decode straight from the state register, so the
    // start bit is on the wire for the whole cycle after the load edge.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_out        = STOP_BIT;
        tx_busy       = 1'b1;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_busy = 1'b0;
                if (ld_tx_data && tx_enable) begin
                    tx_state_next = TX_START;
                    tx_shift_next = tx_data;
                end
            end
            TX_START: begin
                tx_out        = START_BIT;
                tx_cnt_next   = '0;
                tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_out        = tx_shift_reg[0];
                tx_shift_next = tx_shift_reg >> 1;
                tx_cnt_next   = tx_cnt_reg + 1'b1;
                if (tx_cnt_reg == CW'(WIDTH - 1))
                    tx_state_next = TX_STOP;
            end
            TX_STOP: begin
                tx_out        = STOP_BIT;
                tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_cnt_reg   <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_cnt_reg   <= tx_cnt_next;
        end
    end

    uart_fpga_rx #(
        .WIDTH (WIDTH)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .uld_rx_data  (uld_rx_data),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .parity_error (parity_error)
    );

endmodule

// File: tb/tb_uart_fpga.sv
// Directed bench for uart_fpga: TX framing, loopback receive through a scoreboard,
// framing error recovery, overrun, unload collision and mid-frame reset.
module tb_uart_fpga;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] tx_data;
    logic         ld_tx_data;
    logic         tx_enable;
    logic         tx_out;
    logic         tx_busy;
    logic         rx_in;
    logic         uld_rx_data;
    logic [W-1:0] rx_data;
    logic         rx_empty;
    logic         parity_error;

    logic         loopback;
    logic         rx_drv;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         par;
    } exp_t;

    exp_t exp_q[$];

    assign rx_in = loopback ? tx_out : rx_drv;

    always #5 clk = ~clk;

    uart_fpga #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .ld_tx_data   (ld_tx_data),
        .tx_enable    (tx_enable),
        .tx_out       (tx_out),
        .tx_busy      (tx_busy),
        .rx_in        (rx_in),
        .uld_rx_data  (uld_rx_data),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .parity_error (parity_error)
    );

    function automatic logic exp_par(input logic [W-1:0] w);
`ifdef UART_PARITY_CHECK_EN
        return ~^w;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; the load is taken at the following posedge.
    task automatic send(input logic [W-1:0] d, input bit track);
        tx_data    = d;
        tx_enable  = 1'b1;
        ld_tx_data = 1'b1;
        if (track) exp_q.push_back('{d, exp_par(d)});
        @(negedge clk);
        ld_tx_data = 1'b0;
        check("tx_accept", W'(tx_busy), W'(1));
    endtask

    task automatic wait_rx(output int lat);
        lat = 0;
        while (rx_empty && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, W'(0), W'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, rx_data, e.data);
            check({tag, "_parity"}, W'(parity_error), W'(e.par));
            $display("rx %s data=%h parity_error=%0b", tag, rx_data, parity_error);
        end
    endtask

    task automatic drive_frame(input logic [W-1:0] d, input logic stop);
        rx_drv = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            rx_drv = d[i];
        end
        @(negedge clk);
        rx_drv = stop;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] v;
        logic [65:0]  frame;
        int           busy_cnt;
        int           lat;

        reset = 1'b1; tx_data = '0; ld_tx_data = 1'b0; tx_enable = 1'b0;
        uld_rx_data = 1'b0; loopback = 1'b0; rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_out", W'(tx_out), W'(1));
        check("rst_tx_busy", W'(tx_busy), W'(0));
        check("rst_rx_empty", W'(rx_empty), W'(1));
        check("rst_rx_data", rx_data, '0);
        check("rst_parity", W'(parity_error), W'(0));
        reset = 1'b0;
        @(negedge clk);

        // Loads with tx_enable low are dropped.
        tx_enable = 1'b0; ld_tx_data = 1'b1; tx_data = 64'h1234;
        repeat (3) @(negedge clk);
        check("tx_enable_gate", W'(tx_busy), W'(0));
        ld_tx_data = 1'b0; tx_enable = 1'b1;
        @(negedge clk);

        // TX frame capture, with a load attempt mid-frame that must be ignored.
        a = 64'hA5A5_0000_FFFF_0001;
        send(a, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 66; i++) begin
            if (i >= 5 && i < 8) begin
                ld_tx_data = 1'b1;
                tx_data    = ~a;
            end else begin
                ld_tx_data = 1'b0;
            end
            frame[i] = tx_out;
            if (tx_busy) busy_cnt++;
            @(negedge clk);
        end
        check("tx_start_bit", W'(frame[0]), W'(0));
        check("tx_data_bits", frame[64:1], a);
        check("tx_stop_bit", W'(frame[65]), W'(1));
        check("tx_busy_cycles", W'(busy_cnt), W'(66));
        check("tx_busy_fall", W'(tx_busy), W'(0));
        check("tx_idle_high", W'(tx_out), W'(1));
        $display("tx frame=%h busy_cycles=%0d", frame, busy_cnt);

        // Loopback, odd parity word.
        loopback = 1'b1;
        send(64'h0000_0000_0000_0001, 1'b1);
        wait_rx(lat);
        check("lb_odd_latency", W'(lat), W'(66));
        pop_check("lb_odd");
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;
        check("uld_empty", W'(rx_empty), W'(1));
        check("uld_data_hold", rx_data, 64'h1);

        // Loopback, even parity word.
        send(64'h8000_0000_0000_0001, 1'b1);
        wait_rx(lat);
        check("lb_even_latency", W'(lat), W'(66));
        pop_check("lb_even");
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;

        // Framing error: low stop bit, line held low a while before recovering.
        loopback = 1'b0;
        drive_frame(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (80) @(negedge clk);
        check("frame_err_empty", W'(rx_empty), W'(1));
        check("frame_err_hold", rx_data, 64'h8000_0000_0000_0001);
        $display("rx framing error rx_empty=%0b", rx_empty);

        v = {$urandom, $urandom};
        exp_q.push_back('{v, exp_par(v)});
        drive_frame(v, 1'b1);
        @(negedge clk);
        rx_drv = 1'b1;
        check("post_err_empty", W'(rx_empty), W'(0));
        pop_check("post_err");
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;

        // Overrun: two back-to-back frames without unloading.
        loopback = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 1'b1);
        wait_rx(lat);
        check("ovr_a_latency", W'(lat), W'(66));
        pop_check("ovr_a");
        check("ovr_idle_gap", W'(tx_busy), W'(0));
        send(64'hFEDC_BA98_7654_3210, 1'b1);
        repeat (W + 1) @(negedge clk);
        check("ovr_a_still", rx_data, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check("ovr_empty", W'(rx_empty), W'(0));
        pop_check("ovr_b");

        // Unload strobe in the completion cycle loses to the new word.
        send(64'h5555_AAAA_3333_CCCC, 1'b1);
        repeat (W + 1) @(negedge clk);
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;
        check("collide_empty", W'(rx_empty), W'(0));
        pop_check("collide");
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;
        check("collide_uld", W'(rx_empty), W'(1));

        // Reset in the middle of a loopback frame aborts both directions.
        send(64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx_busy", W'(tx_busy), W'(0));
        check("midrst_tx_out", W'(tx_out), W'(1));
        check("midrst_rx_empty", W'(rx_empty), W'(1));
        check("midrst_rx_data", rx_data, '0);
        check("midrst_parity", W'(parity_error), W'(0));
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_no_word", W'(rx_empty), W'(1));
        check("sb_drained", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
